// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between the I-cache refill path and the D-cache
// refill/write-back path; each grant runs a full line burst with fixed per-word latency.
module mem_port_arbiter #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned IDXW       = $clog2(LINE_WORDS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            IReq,
  input  logic [31:0]     IAddr,
  output logic [31:0]     IRdata,
  output logic            IRvalid,
  output logic [IDXW-1:0] IWordIdx,
  output logic            IDone,
  input  logic            DReq,
  input  logic            DWe,
  input  logic [31:0]     DAddr,
  input  logic [31:0]     DWdata,
  output logic [31:0]     DRdata,
  output logic            DRvalid,
  output logic [IDXW-1:0] DWordIdx,
  output logic            DDone,
  output logic [31:0]     MemAddr,
  output logic [31:0]     MemWriteData,
  output logic            MemWb,
  input  logic [31:0]     MemData,
  output logic            Busy
);

  localparam int unsigned    LatW     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned    OffW     = IDXW + 2;
  localparam logic [LatW-1:0] LatLast  = LatW'(MEM_LAT - 1);
  localparam logic [IDXW-1:0] WordLast = IDXW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;            // 1 = D-side owns the burst
  logic            dir_q, dir_d;                // 1 = write-back
  logic            last_grant_q, last_grant_d;  // 1 = D-side was granted last
  logic [31:0]     base_q, base_d;
  logic [IDXW-1:0] word_cnt_q, word_cnt_d;
  logic [LatW-1:0] lat_cnt_q, lat_cnt_d;
  logic            grant;
  logic            xfer, strobe;

  // Line-offset address bits are ignored by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{IAddr[OffW-1:0], DAddr[OffW-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      dir_q        <= 1'b0;
      last_grant_q <= 1'b0;
      base_q       <= '0;
      word_cnt_q   <= '0;
      lat_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      dir_q        <= dir_d;
      last_grant_q <= last_grant_d;
      base_q       <= base_d;
      word_cnt_q   <= word_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    dir_d        = dir_q;
    last_grant_d = last_grant_q;
    base_d       = base_q;
    word_cnt_d   = word_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    grant        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (IReq || DReq) begin
          // On contention the side that did not win last time is served.
          grant        = (IReq && DReq) ? ~last_grant_q : DReq;
          owner_d      = grant;
          last_grant_d = grant;
          dir_d        = grant & DWe;
          base_d       = {(grant ? DAddr[31:OffW] : IAddr[31:OffW]), {OffW{1'b0}}};
          word_cnt_d   = '0;
          lat_cnt_d    = '0;
          state_d      = StXfer;
        end
      end
      StXfer: begin
        if (lat_cnt_q == LatLast) begin
          lat_cnt_d  = '0;
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_q == WordLast) state_d = StDone;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are forced to zero during reset so an abandoned burst leaves no trace.
  always_comb begin
    IRdata       = '0;
    IRvalid      = 1'b0;
    IWordIdx     = '0;
    IDone        = 1'b0;
    DRdata       = '0;
    DRvalid      = 1'b0;
    DWordIdx     = '0;
    DDone        = 1'b0;
    MemAddr      = '0;
    MemWriteData = '0;
    MemWb        = 1'b0;
    xfer         = (state_q == StXfer) && !rst;
    strobe       = xfer && (lat_cnt_q == LatLast);
    Busy         = (state_q != StIdle) && !rst;
    if (xfer) begin
      MemAddr = base_q | {{(30 - IDXW){1'b0}}, word_cnt_q, 2'b00};
      if (owner_q) DWordIdx = word_cnt_q;
      else         IWordIdx = word_cnt_q;
    end
    if (strobe) begin
      if (dir_q) begin
        MemWb        = 1'b1;
        MemWriteData = DWdata;
      end else if (owner_q) begin
        DRvalid = 1'b1;
        DRdata  = MemData;
      end else begin
        IRvalid = 1'b1;
        IRdata  = MemData;
      end
    end
    if ((state_q == StDone) && !rst) begin
      if (owner_q) DDone = 1'b1;
      else         IDone = 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: cycle-offset reference model plus directed
// scenarios with literal expectations, then randomized requesters with sporadic reset.
module tb_mem_port_arbiter;

  localparam int LW = 4;
  localparam int ML = 2;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic IReq = 1'b0, DReq = 1'b0, DWe = 1'b0;
  logic [31:0] IAddr = '0, DAddr = '0, wb_base = '0;
  logic [31:0] IRdata, DRdata, MemAddr, MemWriteData, DWdata, MemData;
  logic IRvalid, IDone, DRvalid, DDone, MemWb, Busy;
  logic [IW-1:0] IWordIdx, DWordIdx;

  // Second instance: single-cycle memory latency, D refill only.
  logic DReq1 = 1'b0;
  logic [31:0] DAddr1 = '0;
  logic [31:0] IRdata1, DRdata1, MemAddr1, MemWriteData1, MemData1;
  logic IRvalid1, IDone1, DRvalid1, DDone1, MemWb1, Busy1;
  logic [IW-1:0] IWordIdx1, DWordIdx1;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  assign DWdata   = wb_base + 32'(DWordIdx);
  assign MemData  = mem_fn(MemAddr);
  assign MemData1 = mem_fn(MemAddr1);

  always #5 clk = ~clk;

  mem_port_arbiter #(.LINE_WORDS(LW), .MEM_LAT(ML)) u_dut (
    .clk(clk), .rst(rst),
    .IReq(IReq), .IAddr(IAddr), .IRdata(IRdata), .IRvalid(IRvalid), .IWordIdx(IWordIdx),
    .IDone(IDone),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWdata(DWdata), .DRdata(DRdata),
    .DRvalid(DRvalid), .DWordIdx(DWordIdx), .DDone(DDone),
    .MemAddr(MemAddr), .MemWriteData(MemWriteData), .MemWb(MemWb), .MemData(MemData),
    .Busy(Busy)
  );

  mem_port_arbiter #(.LINE_WORDS(LW), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .IReq(1'b0), .IAddr(32'h0), .IRdata(IRdata1), .IRvalid(IRvalid1), .IWordIdx(IWordIdx1),
    .IDone(IDone1),
    .DReq(DReq1), .DWe(1'b0), .DAddr(DAddr1), .DWdata(32'h0), .DRdata(DRdata1),
    .DRvalid(DRvalid1), .DWordIdx(DWordIdx1), .DDone(DDone1),
    .MemAddr(MemAddr1), .MemWriteData(MemWriteData1), .MemWb(MemWb1), .MemData(MemData1),
    .Busy(Busy1)
  );

  int n_cmp = 0, n_err = 0;
  int cyc = 0, t0 = 0;

  // Reference model: a burst is (owner, base, dir, grant cycle); outputs follow by offset.
  bit m_busy = 0, m_owner = 0, m_dir = 0, m_last = 0;  // owner/last: 1 = D-side
  int m_start = 0;
  logic [31:0] m_base = '0;
  bit e_idone, e_ddone, e_ddone1;
  bit hold_i = 0, hold_d = 0;

  int irv_c[$], drv_c[$], wb_c[$], done_c[$], drv1_c[$], ddone1_c[$];
  logic [31:0] irv_d[$], wb_a[$], wb_d[$], maddr_log[$], drv1_d[$];
  bit done_s[$];
  int busy_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h, required %h", name, cyc, act, exp);
    end
  endtask

  task automatic check();
    int p, k, w;
    bit xf, dn, st, ai, ad, busy_e;
    logic [31:0] ea;
    busy_e = !rst && m_busy;
    xf = 0; dn = 0; st = 0; w = 0; ea = '0;
    if (busy_e) begin
      p = cyc - m_start;
      if (p <= LW * ML) begin
        xf = 1; k = p - 1; w = k / ML; st = (k % ML) == ML - 1;
        ea = m_base + 32'(4 * w);
      end else dn = 1;
    end
    ai = busy_e && !m_owner;
    ad = busy_e && m_owner;
    e_idone = dn && !m_owner;
    e_ddone = dn && m_owner;
    chk("Busy", Busy, busy_e);
    chk("MemAddr", MemAddr, ea);
    chk("MemWb", MemWb, xf && m_dir && st);
    if (!xf) chk("MemWriteData_idle", MemWriteData, 0);
    else if (m_dir && st) chk("MemWriteData", MemWriteData, wb_base + 32'(w));
    chk("IRvalid", IRvalid, xf && ai && !m_dir && st);
    chk("DRvalid", DRvalid, xf && ad && !m_dir && st);
    chk("IDone", IDone, e_idone);
    chk("DDone", DDone, e_ddone);
    if (xf && ai) chk("IWordIdx", IWordIdx, w);
    else if (!ai) chk("IWordIdx_nonowner", IWordIdx, 0);
    if (xf && ad) chk("DWordIdx", DWordIdx, w);
    else if (!ad) chk("DWordIdx_nonowner", DWordIdx, 0);
    if (xf && ai && st && !m_dir) chk("IRdata", IRdata, mem_fn(ea));
    else if (!ai) chk("IRdata_nonowner", IRdata, 0);
    if (xf && ad && st && !m_dir) chk("DRdata", DRdata, mem_fn(ea));
    else if (!ad) chk("DRdata_nonowner", DRdata, 0);
    // Event log for the directed scenarios, indexed relative to t0.
    e_ddone1 = DDone1;
    maddr_log.push_back(MemAddr);
    if (IRvalid) begin irv_c.push_back(cyc - t0); irv_d.push_back(IRdata); end
    if (DRvalid) drv_c.push_back(cyc - t0);
    if (MemWb) begin
      wb_c.push_back(cyc - t0); wb_a.push_back(MemAddr); wb_d.push_back(MemWriteData);
    end
    if (IDone) begin done_c.push_back(cyc - t0); done_s.push_back(1'b0); end
    if (DDone) begin done_c.push_back(cyc - t0); done_s.push_back(1'b1); end
    if (Busy) busy_n++;
    if (DRvalid1) begin drv1_c.push_back(cyc - t0); drv1_d.push_back(DRdata1); end
    if (DDone1) ddone1_c.push_back(cyc - t0);
  endtask

  task automatic model_step();
    if (rst) begin
      m_busy = 0; m_last = 0;
    end else if (!m_busy) begin
      if (IReq || DReq) begin
        m_owner = (IReq && DReq) ? !m_last : DReq;
        m_last  = m_owner;
        m_busy  = 1;
        m_start = cyc;
        m_dir   = m_owner && DWe;
        m_base  = (m_owner ? DAddr : IAddr) & ~32'(LW * 4 - 1);
      end
    end else if (cyc - m_start == LW * ML + 1) begin
      m_busy = 0;
    end
  endtask

  task automatic cycle();
    #1;
    check();
    model_step();
    cyc++;
    @(negedge clk);
  endtask

  task automatic start_test();
    t0 = cyc; busy_n = 0;
    irv_c.delete(); irv_d.delete(); drv_c.delete(); wb_c.delete(); wb_a.delete();
    wb_d.delete(); done_c.delete(); done_s.delete(); maddr_log.delete();
    drv1_c.delete(); drv1_d.delete(); ddone1_c.delete();
  endtask

  // Requesters drop Req right after their Done; held requesters re-raise one cycle later.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      bit ri, rd;
      ri = hold_i && !IReq;
      rd = hold_d && !DReq;
      cycle();
      if (ri) IReq = 1'b1;
      if (rd) DReq = 1'b1;
      if (e_idone) IReq = 1'b0;
      if (e_ddone) DReq = 1'b0;
      if (e_ddone1) DReq1 = 1'b0;
    end
  endtask

  initial begin
    @(negedge clk);
    run(2);
    chk("reset_Busy", Busy, 0);
    chk("reset_MemAddr", MemAddr, 0);
    rst = 1'b0;

    // Single I refill, plus a D refill on the MEM_LAT=1 instance in parallel.
    IReq = 1'b1; IAddr = 32'h1004; DReq1 = 1'b1; DAddr1 = 32'h3008;
    start_test();
    run(12);
    chk("T1_irv_n", irv_c.size(), 4);
    for (int i = 0; i < irv_c.size(); i++) begin
      chk("T1_irv_cyc", irv_c[i], 2 + 2 * i);
      chk("T1_irdata", irv_d[i], mem_fn(32'h1000 + 32'(4 * i)));
    end
    chk("T1_maddr0", maddr_log[0], 32'h0);
    chk("T1_maddr1", maddr_log[1], 32'h1000);
    chk("T1_maddr4", maddr_log[4], 32'h1004);
    chk("T1_maddr5", maddr_log[5], 32'h1008);
    chk("T1_maddr8", maddr_log[8], 32'h100C);
    chk("T1_maddr9", maddr_log[9], 32'h0);
    chk("T1_done_n", done_c.size(), 1);
    if (done_c.size() > 0) chk("T1_idone_cyc", done_c[0], 9);
    chk("T1_busy_n", busy_n, 9);
    chk("T6_drv_n", drv1_c.size(), 4);
    for (int i = 0; i < drv1_c.size(); i++) begin
      chk("T6_drv_cyc", drv1_c[i], 1 + i);
      chk("T6_drdata", drv1_d[i], mem_fn(32'h3000 + 32'(4 * i)));
    end
    chk("T6_ddone_n", ddone1_c.size(), 1);
    if (ddone1_c.size() > 0) chk("T6_ddone_cyc", ddone1_c[0], 5);

    // D write-back.
    DReq = 1'b1; DWe = 1'b1; DAddr = 32'h2010; wb_base = 32'hA0;
    start_test();
    run(12);
    chk("T2_wb_n", wb_c.size(), 4);
    for (int i = 0; i < wb_c.size(); i++) begin
      chk("T2_wb_cyc", wb_c[i], 2 + 2 * i);
      chk("T2_wb_addr", wb_a[i], 32'h2010 + 32'(4 * i));
      chk("T2_wb_data", wb_d[i], 32'hA0 + 32'(i));
    end
    chk("T2_drv_n", drv_c.size(), 0);
    chk("T2_done_n", done_c.size(), 1);
    if (done_c.size() > 0) chk("T2_ddone_cyc", done_c[0], 9);

    // Simultaneous requests right after reset: D first.
    rst = 1'b1; run(1); rst = 1'b0;
    IReq = 1'b1; DReq = 1'b1; DWe = 1'b0; IAddr = 32'h4000; DAddr = 32'h5000;
    start_test();
    run(22);
    chk("T3_done_n", done_c.size(), 2);
    if (done_c.size() == 2) begin
      chk("T3_first_cyc", done_c[0], 9);
      chk("T3_first_side", done_s[0], 1);
      chk("T3_second_cyc", done_c[1], 19);
      chk("T3_second_side", done_s[1], 0);
    end

    // Both held continuously: strict alternation D, I, D, I.
    hold_i = 1; hold_d = 1; IReq = 1'b1; DReq = 1'b1;
    start_test();
    run(44);
    hold_i = 0; hold_d = 0; IReq = 1'b0; DReq = 1'b0;
    run(12);
    chk("T4_done_n", done_c.size(), 5);
    for (int i = 0; i < 4 && i < done_c.size(); i++) begin
      chk("T4_side", done_s[i], (i % 2 == 0) ? 1 : 0);
      chk("T4_cyc", done_c[i], 9 + 10 * i);
    end

    // Reset mid write-back, then a fresh I refill.
    DReq = 1'b1; DWe = 1'b1; DAddr = 32'h2010; wb_base = 32'hA0;
    start_test();
    run(5);
    rst = 1'b1; DReq = 1'b0;
    run(1);
    rst = 1'b0;
    run(2);
    IReq = 1'b1; IAddr = 32'h1004;
    run(12);
    chk("T5_wb_n", wb_c.size(), 2);
    chk("T5_maddr_rst", maddr_log[5], 32'h0);
    chk("T5_maddr_after", maddr_log[6], 32'h0);
    chk("T5_done_n", done_c.size(), 1);
    if (done_c.size() > 0) begin
      chk("T5_idone_cyc", done_c[0], 17);
      chk("T5_idone_side", done_s[0], 0);
    end

    // Randomized requesters, address/direction churn mid-burst, sporadic reset.
    for (int i = 0; i < 4000; i++) begin
      cycle();
      rst = ($urandom_range(299) == 0);
      wb_base = $urandom;
      if (e_idone) IReq = 1'b0;
      else if (m_busy && !m_owner) begin
        if ($urandom_range(15) == 0) IReq = 1'b0;
        if ($urandom_range(3) == 0) IAddr = $urandom;
      end else if (!IReq && $urandom_range(2) == 0) begin
        IReq = 1'b1; IAddr = $urandom;
      end
      if (e_ddone) DReq = 1'b0;
      else if (m_busy && m_owner) begin
        if ($urandom_range(15) == 0) DReq = 1'b0;
        if ($urandom_range(3) == 0) begin DAddr = $urandom; DWe = 1'($urandom_range(1)); end
      end else if (!DReq && $urandom_range(2) == 0) begin
        DReq = 1'b1; DAddr = $urandom; DWe = 1'($urandom_range(1));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the single external memory port (MemAddr/MemWriteData/MemWb/MemData) between the instruction-cache refill path (read-only) and the data-cache path (refill read or write-back).
- Each grant runs one full cache-line burst of LINE_WORDS words. Each word is given a fixed MEM_LAT-cycle access window.
- Sits between the ICache/DCache miss FSMs and the external memory.
- Arbitrates between the two requesters with round-robin when they contend.

Parameters:
- LINE_WORDS, 4: words per cache-line burst. Must be a power of two, ≥2.
- MEM_LAT, 2: cycles per word access. Must be ≥1.
- IDXW, $clog2(LINE_WORDS): width of the word index outputs.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- IReq  in  1  I-side line refill request. Held until IDone.
- IAddr  in  32  I-side line address. Low IDXW+2 bits are ignored.
- IRdata  out  32  refill word returned to the I-side.
- IRvalid  out  1  IRdata valid this cycle.
- IWordIdx  out  IDXW  index of the word in flight on the I-side.
- IDone  out  1  one-cycle I-side burst-complete pulse.
- DReq  in  1  D-side line request. Held until DDone.
- DWe  in  1  D-side direction: 1 = write-back, 0 = refill.
- DAddr  in  32  D-side line address. Low IDXW+2 bits are ignored.
- DWdata  in  32  write-back word selected by DWordIdx. Supplied combinationally by the requester.
- DRdata  out  32  refill word returned to the D-side.
- DRvalid  out  1  DRdata valid this cycle.
- DWordIdx  out  IDXW  index of the word in flight on the D-side.
- DDone  out  1  one-cycle D-side burst-complete pulse.
- MemAddr  out  32  external memory word address.
- MemWriteData  out  32  external memory write data.
- MemWb  out  1  external memory write strobe.
- MemData  in  32  external memory read data. Valid in the last cycle of each word window.
- Busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset:
  - State goes to IDLE.
  - lastGrant is set to I, so the D-side wins the first tie.
  - Word and latency counters clear.
  - All outputs are 0.
  - A reset during a burst abandons it immediately: no Done pulse is issued and MemWb is 0 in the reset cycle.
- States:
  - IDLE: if DReq and IReq are both high, grant the side opposite lastGrant. If only one is high, grant that side. If neither is high, stay.
  - On a grant: latch the owner, base = addr & ~((LINE_WORDS*4)-1), and dir (DWe for D, 0 for I). Set lastGrant to the owner and go to XFER.
  - XFER: lasts exactly LINE_WORDS*MEM_LAT cycles. wordCnt runs 0..LINE_WORDS-1; latCnt runs 0..MEM_LAT-1 within each word.
    - MemAddr = base + 4*wordCnt for the whole word window.
    - The owner's WordIdx output equals wordCnt.
    - Read: in the cycle latCnt == MEM_LAT-1, the owner's Rvalid = 1 and Rdata = MemData.
    - Write: in the cycle latCnt == MEM_LAT-1, MemWb = 1 and MemWriteData = DWdata. MemWb is 0 in all other cycles.
    - After the last window, go to DONE.
  - DONE: one cycle. The owner's Done = 1, MemWb = 0, then go to IDLE.
- Timing: with the request sampled in IDLE at cycle t, the first Rvalid is at t+MEM_LAT and the Done pulse is at t+LINE_WORDS*MEM_LAT+1.
- Requester protocol: Req must be low by the IDLE cycle that follows Done. A requester that registers its Done response meets this.
- Latching: address and direction are latched at grant, so changes to Req/Addr/DWe during XFER are ignored.
- Req dropped mid-burst: the burst still completes and Done is still pulsed.
- Non-owner outputs (Rvalid, Done, Rdata, WordIdx) read 0 at all times.
- In IDLE and DONE: MemAddr = 0 and MemWriteData = 0.
- Back-to-back bursts: there is a minimum of one IDLE cycle between bursts. A waiting requester is granted in that IDLE cycle.
- Round-robin: with both Req held continuously, grants strictly alternate.

Test Plan:
- Single I refill (LINE_WORDS=4, MEM_LAT=2): IReq=1, IAddr=0x1004 at cycle 0 →
  - MemAddr is 0x1000/0x1004/0x1008/0x100C on cycles 1-2/3-4/5-6/7-8.
  - IRvalid on cycles 2,4,6,8 with IRdata = the memory-model words.
  - IDone on cycle 9; Busy on cycles 1-9.
- D write-back, DAddr=0x2010, DWdata=0xA0+idx → MemWb pulses on cycles 2,4,6,8 at addresses 0x2010..0x201C with data 0xA0..0xA3. DDone on cycle 9; no DRvalid.
- Simultaneous IReq+DReq right after reset → D burst first (DDone cycle 9), IDLE at cycle 10, I granted with IDone at cycle 19.
- Both Req held continuously for four bursts → grant order D, I, D, I. No non-owner Rvalid/Done seen.
- rst asserted at cycle 5 of a D write-back → the cycle-6 MemWb pulse does not occur and no DDone is issued. All outputs are 0, Busy=0. A fresh IReq at cycle 8 gives IDone at cycle 17.
- MEM_LAT=1 build, D refill → DRvalid on 4 consecutive cycles 1..4 and DDone at cycle 5.
